audio_out_feeder: RTL

Downstream stage of the `mem_audio` tone generator. It samples the synthesizer's continuous signed `sound` word at the codec sample rate and buffers the samples in a small FIFO. It then writes each sample to both channels of the audio-codec output port, obeying the codec's space-available handshake. It decouples waveform generation from codec back-pressure and reports dropped samples.

---
 rtl/audio_out_feeder_if.sv | 41 ++++
 rtl/audio_out_feeder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/audio_out_feeder_if.sv
// Codec-side bundle of the audio output feeder: the synthesizer sample in,
// the codec write port out, and the status outputs.
interface audio_out_feeder_if #(
  parameter int AW = 3
);
  logic signed [31:0] sound;
  logic               mute;
  logic               audio_out_allowed;
  logic               clear_flags;
  logic               write_audio_out;
  logic signed [31:0] left_channel_audio_out;
  logic signed [31:0] right_channel_audio_out;
  logic [AW:0]        fill_level;
  logic               overflow;

  // Feeder side: consumes the sample and handshake, drives the codec write.
  modport master (
    input  sound,
    input  mute,
    input  audio_out_allowed,
    input  clear_flags,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out,
    output fill_level,
    output overflow
  );

  // Environment side: synthesizer and codec.
  modport slave (
    output sound,
    output mute,
    output audio_out_allowed,
    output clear_flags,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    input  fill_level,
    input  overflow
  );
endinterface

// File: rtl/audio_out_feeder.sv
// Samples the synthesizer word at the codec rate, buffers it in a small FIFO
// and writes each sample to both codec channels under the codec's
// space-available handshake. Dropped samples raise a sticky overflow flag.
module audio_out_feeder #(
  parameter int DIV   = 1042,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  audio_out_feeder_if.master aif
);

  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [CW-1:0]             tick_cnt;
  logic                      tick;
  logic signed [DATA_W-1:0]  mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               fill;
  logic                      pop;
  logic                      push_ok;
  logic                      drop;
  logic signed [DATA_W-1:0]  sample_p0;
  logic signed [DATA_W-1:0]  chan_p1;
  logic                      wr_p1;
  logic                      ovf_q;

  assign tick      = (tick_cnt == CW'(DIV - 1));
  assign sample_p0 = aif.mute ? '0 : aif.sound;
  // A full FIFO still takes the sample when the head leaves on the same edge.
  assign push_ok   = tick & ((fill < (AW + 1)'(DEPTH)) | pop);
  assign drop      = tick & ~push_ok;

  // Free-running sample-rate divider.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Sample storage; contents are meaningless until the pointers cover them.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      mem[wr_ptr] <= sample_p0;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Drain FSM state register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain FSM next state; the codec handshake is only looked at in IDLE, and
  // HOLD gives the codec a cycle to update its space signal after a write.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((fill != '0) && aif.audio_out_allowed) begin
          pop     = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Codec write port: strobe for one cycle, channel data held until next write.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_p1   <= 1'b0;
      chan_p1 <= '0;
    end else begin
      wr_p1 <= pop;
      if (pop) begin
        chan_p1 <= mem[rd_ptr];
      end
    end
  end

  // Sticky drop flag; a drop on the clearing edge keeps it set.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (aif.clear_flags) begin
      ovf_q <= 1'b0;
    end
  end

  assign aif.write_audio_out         = wr_p1;
  assign aif.left_channel_audio_out  = chan_p1;
  assign aif.right_channel_audio_out = chan_p1;
  assign aif.fill_level              = fill;
  assign aif.overflow                = ovf_q;

endmodule
